rr_interconnect: RTL and testbench

Parametrised N-master, single-slave request/acknowledge interconnect with round-robin arbitration, registered request/response data paths and a slave-response watchdog. It replaces the fixed two-master arbiter in front of shared FPU resources (24-bit adder, exception checker). Booth, the adder and multiplier controllers, and future units can share one slave without fixed priority or starvation.

---
 rtl/rr_interconnect_if.sv | 35 +++
 rtl/rr_interconnect.sv | 121 ++++++++++++
 tb/tb_rr_interconnect.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/rr_interconnect_if.sv
// Bus bundle between N masters, the round-robin interconnect and one slave.
// Modports: ic (interconnect), master (requester view), slave (target view).
interface rr_interconnect_if #(
    parameter int NUM_MASTERS = 4,
    parameter int REQ_DW      = 50,
    parameter int RSP_DW      = 26,
    parameter int SELW        = $clog2(NUM_MASTERS)
);
    logic [NUM_MASTERS-1:0]        M_req;
    logic [NUM_MASTERS*REQ_DW-1:0] M_data;
    logic [NUM_MASTERS-1:0]        M_ack;
    logic [RSP_DW-1:0]             M_rsp;
    logic                          M_err;
    logic                          S_req;
    logic [REQ_DW-1:0]             S_data;
    logic                          S_ack;
    logic [RSP_DW-1:0]             S_rsp;
    logic [SELW-1:0]               Select;
    logic                          BUSY;

    modport ic (
        input  M_req, M_data, S_ack, S_rsp,
        output M_ack, M_rsp, M_err, S_req, S_data, Select, BUSY
    );

    modport master (
        output M_req, M_data,
        input  M_ack, M_rsp, M_err, Select, BUSY
    );

    modport slave (
        input  S_req, S_data, Select,
        output S_ack, S_rsp
    );
endinterface

// File: rtl/rr_interconnect.sv
// N-master / single-slave req/ack interconnect: round-robin grant, latched
// payload/response, slave watchdog. Ports: CLK, RSTn (sync, active low), bus (ic).
module rr_interconnect #(
    parameter int NUM_MASTERS = 4,
    parameter int REQ_DW      = 50,
    parameter int RSP_DW      = 26,
    parameter int TIMEOUT     = 64,
    localparam int SELW       = $clog2(NUM_MASTERS)
) (
    input  logic           CLK,
    input  logic           RSTn,
    rr_interconnect_if.ic  bus
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam int CNTW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNTW-1:0] TO_LAST =
        (TIMEOUT == 0) ? '0 : CNTW'(TIMEOUT - 1);
    localparam logic [SELW-1:0] LAST_RST = SELW'(NUM_MASTERS - 1);

    state_t                 state_q;
    logic [SELW-1:0]        last_q;
    logic [SELW-1:0]        sel_q;
    logic [CNTW-1:0]        cnt_q;
    logic [NUM_MASTERS-1:0] ack_q;
    logic [RSP_DW-1:0]      rsp_q;
    logic                   err_q;
    logic                   sreq_q;
    logic [REQ_DW-1:0]      sdata_q;
    logic                   busy_q;

    logic [REQ_DW-1:0]      mdat [NUM_MASTERS];
    logic                   win_vld_d;
    logic [SELW-1:0]        win_idx_d;
    logic [SELW-1:0]        cand;
    int                     idx;

    for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
        assign mdat[g] = bus.M_data[g*REQ_DW +: REQ_DW];
    end

    // Walk candidates farthest-first so the one nearest to last_q+1
    // overwrites the others and wins.
    always_comb begin
        win_vld_d = 1'b0;
        win_idx_d = '0;
        idx       = 0;
        cand      = '0;
        for (int i = NUM_MASTERS; i >= 1; i--) begin
            idx  = (int'(last_q) + i) % NUM_MASTERS;
            cand = SELW'(idx);
            if (bus.M_req[cand]) begin
                win_vld_d = 1'b1;
                win_idx_d = cand;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q <= IDLE;
            last_q  <= LAST_RST;
            sel_q   <= '0;
            cnt_q   <= '0;
            ack_q   <= '0;
            rsp_q   <= '0;
            err_q   <= 1'b0;
            sreq_q  <= 1'b0;
            sdata_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            ack_q <= '0;
            unique case (state_q)
                IDLE: begin
                    if (win_vld_d) begin
                        sel_q   <= win_idx_d;
                        sdata_q <= mdat[win_idx_d];
                        sreq_q  <= 1'b1;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.S_ack) begin
                        rsp_q   <= bus.S_rsp;
                        err_q   <= 1'b0;
                        sreq_q  <= 1'b0;
                        ack_q   <= NUM_MASTERS'(1) << sel_q;
                        state_q <= RESP;
                    end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
                        rsp_q   <= '0;
                        err_q   <= 1'b1;
                        sreq_q  <= 1'b0;
                        ack_q   <= NUM_MASTERS'(1) << sel_q;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    last_q  <= sel_q;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.M_ack  = ack_q;
    assign bus.M_rsp  = rsp_q;
    assign bus.M_err  = err_q;
    assign bus.S_req  = sreq_q;
    assign bus.S_data = sdata_q;
    assign bus.Select = sel_q;
    assign bus.BUSY   = busy_q;

endmodule

// File: tb/tb_rr_interconnect.sv
// Directed bench for rr_interconnect: 4 masters, TIMEOUT=8.
// Covers reset, fairness, pointer wrap, payload latch, timeout, mid-reset.
module tb_rr_interconnect;

    localparam int NM  = 4;
    localparam int RDW = 50;
    localparam int SDW = 26;

    logic CLK = 1'b0;
    logic RSTn;
    int   checks = 0;
    int   errors = 0;
    int   ack_cnt [NM];

    rr_interconnect_if #(.NUM_MASTERS(NM), .REQ_DW(RDW), .RSP_DW(SDW)) bus ();

    rr_interconnect #(
        .NUM_MASTERS(NM), .REQ_DW(RDW), .RSP_DW(SDW), .TIMEOUT(8)
    ) dut (
        .CLK  (CLK),
        .RSTn (RSTn),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_data(input int m, input logic [RDW-1:0] v);
        bus.M_data[m*RDW +: RDW] = v;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_mack"}, 64'(bus.M_ack), 64'h0);
        chk({tag, "_mrsp"}, 64'(bus.M_rsp), 64'h0);
        chk({tag, "_merr"}, 64'(bus.M_err), 64'h0);
        chk({tag, "_sreq"}, 64'(bus.S_req), 64'h0);
        chk({tag, "_sdat"}, 64'(bus.S_data), 64'h0);
        chk({tag, "_sel"},  64'(bus.Select), 64'h0);
        chk({tag, "_busy"}, 64'(bus.BUSY), 64'h0);
    endtask

    // Called during an IDLE cycle with requests already set up; returns
    // in the following IDLE cycle.
    task automatic txn(input int sel, input logic [RDW-1:0] dat,
                       input int dly, input logic [SDW-1:0] rsp,
                       input bit mutate);
        logic [NM-1:0] oh;
        oh = 4'b0001 << sel;
        tick();
        chk("grant_sreq", 64'(bus.S_req), 64'h1);
        chk("grant_sel",  64'(bus.Select), 64'(sel));
        chk("grant_data", 64'(bus.S_data), 64'(dat));
        chk("grant_busy", 64'(bus.BUSY), 64'h1);
        if (mutate) set_data(sel, ~dat);
        repeat (dly) begin
            tick();
            chk("hold_sreq", 64'(bus.S_req), 64'h1);
            chk("hold_data", 64'(bus.S_data), 64'(dat));
            chk("hold_sel",  64'(bus.Select), 64'(sel));
        end
        bus.S_ack = 1'b1;
        bus.S_rsp = rsp;
        tick();
        bus.S_ack = 1'b0;
        bus.S_rsp = '0;
        chk("ack_mack", 64'(bus.M_ack), 64'(oh));
        chk("ack_mrsp", 64'(bus.M_rsp), 64'(rsp));
        chk("ack_merr", 64'(bus.M_err), 64'h0);
        chk("ack_sreq", 64'(bus.S_req), 64'h0);
        chk("ack_busy", 64'(bus.BUSY), 64'h1);
        for (int i = 0; i < NM; i++)
            if (bus.M_ack[i]) ack_cnt[i]++;
        tick();
        chk("idle_mack", 64'(bus.M_ack), 64'h0);
        chk("idle_busy", 64'(bus.BUSY), 64'h0);
    endtask

    initial begin
        int hi_cnt;
        for (int i = 0; i < NM; i++) ack_cnt[i] = 0;
        RSTn       = 1'b0;
        bus.M_req  = '0;
        bus.M_data = '0;
        bus.S_ack  = 1'b0;
        bus.S_rsp  = '0;
        repeat (3) tick();
        chk_reset("rst");
        RSTn = 1'b1;
        tick();

        // Fairness: all requests held, slave acks in first WAIT cycle
        for (int i = 0; i < NM; i++) set_data(i, RDW'(50'h100 + i));
        bus.M_req = 4'b1111;
        txn(0, 50'h100, 0, 26'h10, 1'b0);
        txn(1, 50'h101, 0, 26'h11, 1'b0);
        txn(2, 50'h102, 0, 26'h12, 1'b0);
        txn(3, 50'h103, 0, 26'h13, 1'b0);
        for (int i = 0; i < NM; i++)
            chk("fair_cnt", 64'(ack_cnt[i]), 64'h1);
        txn(0, 50'h100, 0, 26'h14, 1'b0);
        txn(1, 50'h101, 0, 26'h15, 1'b0);
        bus.M_req = '0;

        // Pointer wrap: last grant 1, requests {0,3} -> 3 then 0
        bus.M_req = 4'b1001;
        txn(3, 50'h103, 0, 26'h21, 1'b0);
        bus.M_req = 4'b0001;
        txn(0, 50'h100, 0, 26'h22, 1'b0);
        bus.M_req = '0;

        // Single master with delayed ack
        set_data(2, 50'h1234);
        bus.M_req = 4'b0100;
        txn(2, 50'h1234, 2, 26'h55, 1'b0);
        bus.M_req = '0;

        // Payload latched at grant even if M_data changes
        set_data(0, 50'hABCDE);
        bus.M_req = 4'b0001;
        txn(0, 50'hABCDE, 1, 26'h77, 1'b1);
        bus.M_req = '0;

        // Timeout on master 1
        set_data(1, 50'h42);
        bus.M_req = 4'b0010;
        hi_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.S_req) hi_cnt++;
            else break;
        end
        chk("to_sreq_len", 64'(hi_cnt), 64'd8);
        chk("to_mack", 64'(bus.M_ack), 64'h2);
        chk("to_merr", 64'(bus.M_err), 64'h1);
        chk("to_mrsp", 64'(bus.M_rsp), 64'h0);
        tick();
        bus.M_req = '0;
        chk("to_idle_mack", 64'(bus.M_ack), 64'h0);
        tick();
        bus.S_ack = 1'b1;
        bus.S_rsp = 26'h3FF;
        tick();
        bus.S_ack = 1'b0;
        bus.S_rsp = '0;
        chk("late_mack", 64'(bus.M_ack), 64'h0);
        chk("late_sreq", 64'(bus.S_req), 64'h0);
        chk("late_busy", 64'(bus.BUSY), 64'h0);
        chk("late_mrsp", 64'(bus.M_rsp), 64'h0);
        chk("late_merr", 64'(bus.M_err), 64'h0);

        // Reset while in WAIT, then priority restarts at master 0
        set_data(0, 50'h5A5A);
        bus.M_req = 4'b1001;
        tick();
        chk("mid_sreq", 64'(bus.S_req), 64'h1);
        chk("mid_sel",  64'(bus.Select), 64'h3);
        RSTn = 1'b0;
        tick();
        RSTn = 1'b1;
        chk_reset("mid_rst");
        txn(0, 50'h5A5A, 0, 26'h11, 1'b0);
        bus.M_req = '0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
